// File: rtl/block_reader.sv
// Double-banked block buffer: the SD read path fills one bank while the other
// bank streams out one word per cycle through a registered output.
module block_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 9
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  abort,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  wr_overflow,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            blocks_avail
);

  localparam int DEPTH = 1 << SIZE;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t                state_q, state_d;
  logic [1:0]            full_q, full_d;
  logic                  wbank_q, wbank_d;
  logic                  rbank_q, rbank_d;
  logic [SIZE-1:0]       wptr_q, wptr_d;
  logic [SIZE-1:0]       rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  wr_overflow_q, wr_overflow_d;

  logic [DATA_WIDTH-1:0] mem [0:2*DEPTH-1];
  logic                  mem_we;
  logic [SIZE:0]         mem_waddr;
  logic [SIZE:0]         mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign wr_ready     = ~full_q[wbank_q];
  assign wr_overflow  = wr_overflow_q;
  assign out_valid    = (state_q == STREAM);
  assign out_last     = (state_q == STREAM) && (rptr_q == '1);
  assign out_data     = out_data_q;
  assign blocks_avail = {1'b0, full_q[0]} + {1'b0, full_q[1]};

  // LOAD fetches the word at rptr; STREAM prefetches the next word so an
  // accepted word is replaced on the very next edge.
  assign mem_waddr = {wbank_q, wptr_q};
  assign mem_raddr = {rbank_q, (state_q == LOAD) ? rptr_q : rptr_q + SIZE'(1)};
  assign mem_rdata = mem[mem_raddr];

  always_comb begin
    state_d       = state_q;
    full_d        = full_q;
    wbank_d       = wbank_q;
    rbank_d       = rbank_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    out_data_d    = out_data_q;
    wr_overflow_d = wr_overflow_q;
    mem_we        = 1'b0;

    if (abort) begin
      state_d       = IDLE;
      full_d        = '0;
      wbank_d       = 1'b0;
      rbank_d       = 1'b0;
      wptr_d        = '0;
      rptr_d        = '0;
      wr_overflow_d = 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_ready) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + SIZE'(1);
          if (wptr_q == '1) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
          end
        end else begin
          wr_overflow_d = 1'b1;
        end
      end

      // Writes only target an EMPTY bank and reads only a FULL one, so the
      // two full_d updates below never touch the same bank.
      case (state_q)
        IDLE: begin
          if (full_q[rbank_q]) state_d = LOAD;
        end
        LOAD: begin
          out_data_d = mem_rdata;
          state_d    = STREAM;
        end
        STREAM: begin
          if (out_ready) begin
            if (rptr_q == '1) begin
              full_d[rbank_q] = 1'b0;
              rbank_d         = ~rbank_q;
              rptr_d          = '0;
              state_d         = IDLE;
            end else begin
              rptr_d     = rptr_q + SIZE'(1);
              out_data_d = mem_rdata;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      full_q        <= '0;
      wbank_q       <= 1'b0;
      rbank_q       <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      out_data_q    <= '0;
      wr_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      wbank_q       <= wbank_d;
      rbank_q       <= rbank_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      out_data_q    <= out_data_d;
      wr_overflow_q <= wr_overflow_d;
    end
  end

  // Storage is deliberately outside reset; contents are invalidated via full_q.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= wr_data;
  end

endmodule

// File: tb/tb_block_reader.sv
// Directed bench for block_reader: a SIZE=2 instance for the protocol cases
// and a SIZE=9 instance for a full 512-word block.
module tb_block_reader;

  logic       clk = 1'b0;
  logic       resetn;
  logic       abort;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       wr_overflow;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] blocks_avail;

  logic       b_abort;
  logic       b_wr_en;
  logic [7:0] b_wr_data;
  logic       b_wr_ready;
  logic       b_wr_overflow;
  logic       b_out_valid;
  logic       b_out_ready;
  logic [7:0] b_out_data;
  logic       b_out_last;
  logic [1:0] b_blocks_avail;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  block_reader #(.DATA_WIDTH(8), .SIZE(2)) dut (
    .clk(clk), .resetn(resetn), .abort(abort),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready), .wr_overflow(wr_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .blocks_avail(blocks_avail)
  );

  block_reader #(.DATA_WIDTH(8), .SIZE(9)) dut_big (
    .clk(clk), .resetn(resetn), .abort(b_abort),
    .wr_en(b_wr_en), .wr_data(b_wr_data), .wr_ready(b_wr_ready), .wr_overflow(b_wr_overflow),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .blocks_avail(b_blocks_avail)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // {valid, last, data} packed together so one vector covers a stream beat
  function automatic logic [31:0] beat(input logic v, input logic l, input logic [7:0] d);
    return {22'd0, v, l, d};
  endfunction

  initial begin
    resetn = 1'b0; abort = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
    b_abort = 1'b0; b_wr_en = 1'b0; b_wr_data = '0; b_out_ready = 1'b0;
    #12;
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_beat", beat(out_valid, out_last, out_data), beat(1'b0, 1'b0, 8'h00));
    chk("rst_avail", 32'(blocks_avail), 32'd0);
    chk("rst_ovf", 32'(wr_overflow), 32'd0);
    resetn = 1'b1;
    tick();

    // Single block, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) write_word(8'(8'h10 + i));
    chk("b1_avail_full", 32'(blocks_avail), 32'd1);
    chk("b1_e0_valid", 32'(out_valid), 32'd0);
    tick();
    chk("b1_e1_valid", 32'(out_valid), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("b1_beat", beat(out_valid, out_last, out_data), beat(1'b1, i == 3, 8'(8'h10 + i)));
      tick();
    end
    chk("b1_done_valid", 32'(out_valid), 32'd0);
    chk("b1_avail_empty", 32'(blocks_avail), 32'd0);

    // Both banks full, overflow, then drain with inter-block gap
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(8'(8'h20 + i));
    chk("b2_avail2", 32'(blocks_avail), 32'd2);
    chk("b2_wr_ready0", 32'(wr_ready), 32'd0);
    write_word(8'h99);
    chk("b2_ovf", 32'(wr_overflow), 32'd1);
    chk("b2_avail_after_ovf", 32'(blocks_avail), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b2_beat_a", beat(out_valid, out_last, out_data), beat(1'b1, i == 3, 8'(8'h20 + i)));
      tick();
    end
    chk("b2_wr_ready_freed", 32'(wr_ready), 32'd1);
    chk("b2_avail1", 32'(blocks_avail), 32'd1);
    chk("b2_gap1", 32'(out_valid), 32'd0);
    tick();
    chk("b2_gap2", 32'(out_valid), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("b2_beat_b", beat(out_valid, out_last, out_data), beat(1'b1, i == 3, 8'(8'h24 + i)));
      tick();
    end
    chk("b2_avail0", 32'(blocks_avail), 32'd0);
    chk("b2_ovf_sticky", 32'(wr_overflow), 32'd1);

    // Backpressure: each word presented for a stalled cycle then accepted
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'(8'h40 + i));
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b0;
      chk("bp_beat", beat(out_valid, out_last, out_data), beat(1'b1, i == 3, 8'(8'h40 + i)));
      tick();
      chk("bp_hold", beat(out_valid, out_last, out_data), beat(1'b1, i == 3, 8'(8'h40 + i)));
      out_ready = 1'b1;
      tick();
    end
    chk("bp_done", 32'(out_valid), 32'd0);

    // Abort mid-block, colliding with a write
    write_word(8'h50);
    write_word(8'h51);
    abort = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    abort = 1'b0; wr_en = 1'b0;
    chk("ab_avail", 32'(blocks_avail), 32'd0);
    chk("ab_ovf", 32'(wr_overflow), 32'd0);
    chk("ab_wr_ready", 32'(wr_ready), 32'd1);
    chk("ab_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) write_word(8'(8'h30 + i));
    chk("ab_wptr_reset", 32'(blocks_avail), 32'd0);
    write_word(8'h33);
    chk("ab_full", 32'(blocks_avail), 32'd1);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("ab_beat", beat(out_valid, out_last, out_data), beat(1'b1, i == 3, 8'(8'h30 + i)));
      tick();
    end

    // Asynchronous reset after two words accepted
    for (int i = 0; i < 4; i++) write_word(8'(8'h60 + i));
    tick();
    tick();
    tick();
    tick();
    chk("rs_pre", beat(out_valid, out_last, out_data), beat(1'b1, 1'b0, 8'h62));
    resetn = 1'b0;
    #1;
    chk("rs_beat", beat(out_valid, out_last, out_data), beat(1'b0, 1'b0, 8'h00));
    chk("rs_avail", 32'(blocks_avail), 32'd0);
    chk("rs_wr_ready", 32'(wr_ready), 32'd1);
    #1;
    resetn = 1'b1;
    tick();

    // Write of the next block completes on the same edge the current one is released
    for (int i = 0; i < 4; i++) write_word(8'(8'h70 + i));
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("ov_beat", beat(out_valid, out_last, out_data), beat(1'b1, i == 3, 8'(8'h70 + i)));
      chk("ov_avail", 32'(blocks_avail), 32'd1);
      wr_en = 1'b1; wr_data = 8'(8'h80 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("ov_avail_same", 32'(blocks_avail), 32'd1);
    chk("ov_gap", 32'(out_valid), 32'd0);
    chk("ov_wr_ready", 32'(wr_ready), 32'd1);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("ov_beat2", beat(out_valid, out_last, out_data), beat(1'b1, i == 3, 8'(8'h80 + i)));
      tick();
    end
    chk("ov_avail_end", 32'(blocks_avail), 32'd0);

    // Full-size block on the SIZE=9 instance
    b_out_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      b_wr_en = 1'b1; b_wr_data = 8'(i % 256);
      tick();
    end
    b_wr_en = 1'b0;
    chk("big_avail", 32'(b_blocks_avail), 32'd1);
    tick();
    tick();
    for (int i = 0; i < 512; i++) begin
      chk("big_beat", beat(b_out_valid, b_out_last, b_out_data), beat(1'b1, i == 511, 8'(i % 256)));
      tick();
    end
    chk("big_done", 32'(b_out_valid), 32'd0);
    chk("big_avail0", 32'(b_blocks_avail), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
